// File: rtl/game_pkg.sv
// Shared types and constants for the puzzle board controller and its helpers.
// Cells are {value, locked}; a value of 0 means the cell is empty.
package game_pkg;
    localparam int BOARD_DIM    = 16;
    localparam int DEFAULT_SIZE = 3;

    typedef struct packed {
        logic [4:0] value;
        logic       locked;
    } cell_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;
endpackage

// File: rtl/cursor_wrap.sv
// Combinational next coordinate for one cursor axis, wrapping inside 0..N-1.
// dec=1 steps toward 0, dec=0 steps toward N-1.
module cursor_wrap (
    input  logic [3:0] coord,
    input  logic [4:0] n,
    input  logic       dec,
    output logic [3:0] next_coord
);
    logic [3:0] last;

    // N is at most 16, so N-1 always fits in four bits.
    assign last = 4'(n - 5'd1);

    always_comb begin
        next_coord = coord;
        if (dec) begin
            next_coord = (coord == 4'd0) ? last : coord - 4'd1;
        end else begin
            next_coord = (coord == last) ? 4'd0 : coord + 4'd1;
        end
    end
endmodule

// File: rtl/game_board_controller.sv
// Puzzle state owner: sweeps the board from the puzzle ROM on new_game, then applies
// cursor moves and digit entries while in PLAY. All outputs are registered state.
module game_board_controller
    import game_pkg::*;
#(
    parameter int PUZZLE_ID_W  = 4,
    parameter int DEFAULT_SIZE = game_pkg::DEFAULT_SIZE
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         new_game,
    input  logic [2:0]                                   size_req,
    input  logic [PUZZLE_ID_W-1:0]                       puzzle_id,
    input  logic                                         move_valid,
    input  logic [1:0]                                   move_dir,
    input  logic                                         digit_valid,
    input  logic [4:0]                                   digit,
    output logic [PUZZLE_ID_W+7:0]                       rom_addr,
    input  logic [4:0]                                   rom_data,
    output logic [BOARD_DIM-1:0][BOARD_DIM-1:0][5:0]     board,
    output logic [3:0]                                   selection_x,
    output logic [3:0]                                   selection_y,
    output logic [2:0]                                   board_size,
    output logic                                         is_game_on,
    output logic                                         busy
);
    state_t                 state, state_nxt;
    logic [7:0]             cnt;
    logic [PUZZLE_ID_W-1:0] pid_q;
    logic                   wr_vld;
    logic                   wr_last;
    logic [3:0]             wr_x;
    logic [3:0]             wr_y;
    logic [4:0]             n;
    logic [2:0]             size_sel;
    logic                   load_ok;
    logic                   cur_locked;
    logic [3:0]             x_next;
    logic [3:0]             y_next;
    dir_t                   mdir;

    assign n          = 5'(board_size) * 5'(board_size);
    assign size_sel   = (size_req >= 3'd2 && size_req <= 3'd4) ? size_req : 3'(DEFAULT_SIZE);
    assign rom_addr   = {pid_q, cnt};
    assign is_game_on = (state == PLAY);
    assign busy       = (state == LOAD);
    assign mdir       = dir_t'(move_dir);
    assign cur_locked = board[selection_y][selection_x][0];

    // Givens outside the active N x N area or above N are dropped as empty.
    assign load_ok = ({1'b0, wr_x} < n) && ({1'b0, wr_y} < n) &&
                     (rom_data != 5'd0) && (rom_data <= n);

    cursor_wrap u_wrap_x (
        .coord      (selection_x),
        .n          (n),
        .dec        (mdir == LEFT),
        .next_coord (x_next)
    );

    cursor_wrap u_wrap_y (
        .coord      (selection_y),
        .n          (n),
        .dec        (mdir == UP),
        .next_coord (y_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (new_game) begin
            state_nxt = LOAD;
        end else if (state == LOAD && wr_vld && wr_last) begin
            state_nxt = PLAY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            board       <= '0;
            selection_x <= 4'd0;
            selection_y <= 4'd0;
            board_size  <= 3'(DEFAULT_SIZE);
            pid_q       <= '0;
            cnt         <= 8'd0;
            wr_vld      <= 1'b0;
            wr_last     <= 1'b0;
            wr_x        <= 4'd0;
            wr_y        <= 4'd0;
        end else if (new_game) begin
            board_size  <= size_sel;
            pid_q       <= puzzle_id;
            cnt         <= 8'd0;
            wr_vld      <= 1'b0;
            wr_last     <= 1'b0;
            selection_x <= 4'd0;
            selection_y <= 4'd0;
        end else if (state == LOAD) begin
            // rom_data answers the address issued one cycle earlier, so the cell
            // coordinates ride one register stage behind the counter.
            cnt     <= cnt + 8'd1;
            wr_vld  <= !(wr_vld && wr_last);
            wr_last <= (cnt == 8'hFF);
            wr_x    <= cnt[3:0];
            wr_y    <= cnt[7:4];
            if (wr_vld) begin
                board[wr_y][wr_x] <= load_ok ? cell_t'{value: rom_data, locked: 1'b1} : '0;
            end
        end else if (state == PLAY) begin
            if (digit_valid && !cur_locked && digit <= n) begin
                board[selection_y][selection_x] <= cell_t'{value: digit, locked: 1'b0};
            end
            if (move_valid) begin
                if (mdir == UP || mdir == DOWN) selection_y <= y_next;
                else                            selection_x <= x_next;
            end
        end
    end
endmodule
